// File: rtl/hft_pkg.sv
// Shared definitions for the quote egress path.
//   REG_WIDTH     : parser register / stream word width
//   ADD_MSG_WORDS : words in one ITCH-style add-order message
//   ITCH_ADD_TYPE : ITCH message type byte for add-order
//   ser_state_t   : serializer FSM states
package hft_pkg;

    localparam int unsigned REG_WIDTH     = 32;
    localparam int unsigned ADD_MSG_WORDS = 9;
    localparam logic [7:0]  ITCH_ADD_TYPE = 8'h41;

    typedef enum logic [1:0] {
        IDLE,
        SEND_B,
        SEND_S
    } ser_state_t;

endpackage

// File: rtl/order_frame_buf.sv
// Capture register for one quote pair (buy + sell message words).
// With ORDER_SER_CHECKSUM_EN defined, also holds the per-side XOR checksum,
// computed from the incoming words at capture time.
// Ports:
//   clk, rst_n  : clock, async active-low reset (clears the buffer)
//   capture     : load reg_b/reg_s (and checksums) at the next edge
//   reg_b/reg_s : packed buy/sell words, word k at [k*REG_WIDTH +: REG_WIDTH]
//   words_b/s   : stored words, index k = message word k
//   csum_b/s    : stored XOR of the 9 words per side (checksum build only)
module order_frame_buf
    import hft_pkg::*;
#(
    parameter int unsigned REG_WIDTH = hft_pkg::REG_WIDTH,
    parameter int unsigned MSG_WORDS = hft_pkg::ADD_MSG_WORDS
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           capture,
    input  logic [MSG_WORDS*REG_WIDTH-1:0] reg_b,
    input  logic [MSG_WORDS*REG_WIDTH-1:0] reg_s,
    output logic [REG_WIDTH-1:0]           words_b [MSG_WORDS],
    output logic [REG_WIDTH-1:0]           words_s [MSG_WORDS]
`ifdef ORDER_SER_CHECKSUM_EN
    ,
    output logic [REG_WIDTH-1:0]           csum_b,
    output logic [REG_WIDTH-1:0]           csum_s
`endif
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            words_b <= '{default: '0};
            words_s <= '{default: '0};
        end else if (capture) begin
            for (int unsigned k = 0; k < MSG_WORDS; k++) begin
                words_b[k] <= reg_b[k*REG_WIDTH +: REG_WIDTH];
                words_s[k] <= reg_s[k*REG_WIDTH +: REG_WIDTH];
            end
        end
    end

`ifdef ORDER_SER_CHECKSUM_EN
    logic [REG_WIDTH-1:0] xor_b;
    logic [REG_WIDTH-1:0] xor_s;

    always_comb begin
        xor_b = '0;
        xor_s = '0;
        for (int unsigned k = 0; k < MSG_WORDS; k++) begin
            xor_b = xor_b ^ reg_b[k*REG_WIDTH +: REG_WIDTH];
            xor_s = xor_s ^ reg_s[k*REG_WIDTH +: REG_WIDTH];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum_b <= '0;
            csum_s <= '0;
        end else if (capture) begin
            csum_b <= xor_b;
            csum_s <= xor_s;
        end
    end
`endif

endmodule

// File: rtl/order_msg_serializer.sv
// Serializes one captured quote pair as a 32-bit valid/ready word stream:
// buy message (reg_0..reg_8) then sell message. Quotes arriving while a
// frame is in flight are dropped and counted (saturating).
// Optional feature macro: ORDER_SER_CHECKSUM_EN appends an XOR checksum word
// to each message and moves o_last onto it.
// Ports:
//   i_clk, i_rst_n  : clock, async active-low reset
//   i_valid         : one-cycle quote strobe
//   i_reg_b/i_reg_s : packed buy/sell words, word k at [k*REG_WIDTH +: REG_WIDTH]
//   o_in_ready      : comb; a quote presented this cycle is accepted
//   o_data/o_valid  : stream word / valid, i_ready = downstream accept
//   o_sof/o_last    : first / final word of each message
//   o_side          : 0 = buy message, 1 = sell message
//   o_drop_cnt      : saturating count of dropped quotes
module order_msg_serializer
    import hft_pkg::*;
#(
    parameter int unsigned REG_WIDTH  = hft_pkg::REG_WIDTH,
    parameter int unsigned MSG_WORDS  = hft_pkg::ADD_MSG_WORDS,
    parameter int unsigned DROP_CNT_W = 16
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic                           i_valid,
    input  logic [MSG_WORDS*REG_WIDTH-1:0] i_reg_b,
    input  logic [MSG_WORDS*REG_WIDTH-1:0] i_reg_s,
    output logic                           o_in_ready,
    output logic [REG_WIDTH-1:0]           o_data,
    output logic                           o_valid,
    input  logic                           i_ready,
    output logic                           o_sof,
    output logic                           o_last,
    output logic                           o_side,
    output logic [DROP_CNT_W-1:0]          o_drop_cnt
);

`ifdef ORDER_SER_CHECKSUM_EN
    localparam int unsigned BEATS = MSG_WORDS + 1;
`else
    localparam int unsigned BEATS = MSG_WORDS;
`endif
    localparam int unsigned      IDX_W    = $clog2(BEATS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

    ser_state_t state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    logic xfer;
    logic is_last;
    logic accept;
    logic drop;

    logic [REG_WIDTH-1:0] words_b [MSG_WORDS];
    logic [REG_WIDTH-1:0] words_s [MSG_WORDS];
    logic [REG_WIDTH-1:0] word_b;
    logic [REG_WIDTH-1:0] word_s;

    logic [REG_WIDTH-1:0] data_d;
    logic                 valid_d;
    logic                 sof_d;
    logic                 last_d;
    logic                 side_d;

`ifdef ORDER_SER_CHECKSUM_EN
    logic [REG_WIDTH-1:0] csum_b;
    logic [REG_WIDTH-1:0] csum_s;
`endif

    order_frame_buf #(
        .REG_WIDTH(REG_WIDTH),
        .MSG_WORDS(MSG_WORDS)
    ) u_frame_buf (
        .clk     (i_clk),
        .rst_n   (i_rst_n),
        .capture (accept),
        .reg_b   (i_reg_b),
        .reg_s   (i_reg_s),
        .words_b (words_b),
        .words_s (words_s)
`ifdef ORDER_SER_CHECKSUM_EN
        ,
        .csum_b  (csum_b),
        .csum_s  (csum_s)
`endif
    );

    // Handshake, accept/drop decode and next state.
    always_comb begin
        xfer       = o_valid && i_ready;
        is_last    = (idx_q == LAST_IDX);
        o_in_ready = (state_q == IDLE) || ((state_q == SEND_S) && is_last && xfer);
        accept     = i_valid && o_in_ready;
        drop       = i_valid && !o_in_ready;

        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SEND_B;
                    idx_d   = '0;
                end
            end
            SEND_B: begin
                if (xfer) begin
                    if (is_last) begin
                        state_d = SEND_S;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            SEND_S: begin
                if (xfer) begin
                    if (is_last) begin
                        state_d = accept ? SEND_B : IDLE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // Word mux indexed by the next index, so the stream outputs can be
    // registered without adding a cycle of latency.
    always_comb begin
        word_b = '0;
        word_s = '0;
        for (int unsigned k = 0; k < MSG_WORDS; k++) begin
            if (idx_d == IDX_W'(k)) begin
                word_b = words_b[k];
                word_s = words_s[k];
            end
        end
`ifdef ORDER_SER_CHECKSUM_EN
        if (idx_d == LAST_IDX) begin
            word_b = csum_b;
            word_s = csum_s;
        end
`endif
    end

    // A quote accepted this cycle is not in the buffer until the edge, so
    // buy word 0 of a new frame is taken straight from the input bus.
    always_comb begin
        data_d = '0;
        if (accept) begin
            data_d = i_reg_b[REG_WIDTH-1:0];
        end else if (state_d == SEND_B) begin
            data_d = word_b;
        end else if (state_d == SEND_S) begin
            data_d = word_s;
        end
        valid_d = (state_d != IDLE);
        sof_d   = valid_d && (idx_d == '0);
        last_d  = valid_d && (idx_d == LAST_IDX);
        side_d  = (state_d == SEND_S);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            o_valid <= 1'b0;
            o_data  <= '0;
            o_sof   <= 1'b0;
            o_last  <= 1'b0;
            o_side  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            o_valid <= valid_d;
            o_data  <= data_d;
            o_sof   <= sof_d;
            o_last  <= last_d;
            o_side  <= side_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_drop_cnt <= '0;
        end else if (drop && (o_drop_cnt != '1)) begin
            o_drop_cnt <= o_drop_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_order_msg_serializer.sv
// Self-checking bench for order_msg_serializer (default or
// ORDER_SER_CHECKSUM_EN build). Expected beats are pushed to a scoreboard
// queue when a quote is driven and popped when the DUT transfers a word.
module tb_order_msg_serializer;

    localparam int W = 32;
    localparam int N = 9;
`ifdef ORDER_SER_CHECKSUM_EN
    localparam int BEATS = N + 1;
`else
    localparam int BEATS = N;
`endif

    logic           i_clk;
    logic           i_rst_n;
    logic           i_valid;
    logic [N*W-1:0] i_reg_b;
    logic [N*W-1:0] i_reg_s;
    logic           o_in_ready;
    logic [W-1:0]   o_data;
    logic           o_valid;
    logic           i_ready;
    logic           o_sof;
    logic           o_last;
    logic           o_side;
    logic [15:0]    o_drop_cnt;

    order_msg_serializer #(
        .REG_WIDTH (W),
        .MSG_WORDS (N),
        .DROP_CNT_W(16)
    ) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_valid    (i_valid),
        .i_reg_b    (i_reg_b),
        .i_reg_s    (i_reg_s),
        .o_in_ready (o_in_ready),
        .o_data     (o_data),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_sof      (o_sof),
        .o_last     (o_last),
        .o_side     (o_side),
        .o_drop_cnt (o_drop_cnt)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [W-1:0] data;
        logic         sof;
        logic         last;
        logic         side;
    } exp_t;

    typedef struct {
        logic [W-1:0] b_base;
        logic [W-1:0] s_base;
        int           stall_beat;
        int           stall_len;
        int           drop_at;
        int           exp_cycles;
    } vec_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad   = 0;
    logic [15:0] exp_drops = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] msg_word(input logic [W-1:0] base, input int k);
        logic [W-1:0] x;
        if (k < N) return base + W'(k);
        x = '0;
        for (int j = 0; j < N; j++) x = x ^ (base + W'(j));
        return x;
    endfunction

    function automatic logic [W-1:0] beat_word(input vec_t v, input int beat);
        if (beat < BEATS) return msg_word(v.b_base, beat);
        return msg_word(v.s_base, beat - BEATS);
    endfunction

    task automatic load_quote(input logic [W-1:0] b, input logic [W-1:0] s);
        for (int k = 0; k < N; k++) begin
            i_reg_b[k*W +: W] = b + W'(k);
            i_reg_s[k*W +: W] = s + W'(k);
        end
    endtask

    task automatic push_frame(input logic [W-1:0] b, input logic [W-1:0] s);
        exp_t e;
        for (int beat = 0; beat < 2*BEATS; beat++) begin
            e.data = (beat < BEATS) ? msg_word(b, beat) : msg_word(s, beat - BEATS);
            e.sof  = ((beat % BEATS) == 0);
            e.last = ((beat % BEATS) == BEATS - 1);
            e.side = (beat >= BEATS);
            sb.push_back(e);
        end
    endtask

    task automatic note_drop();
        if (exp_drops != 16'hFFFF) exp_drops = exp_drops + 16'd1;
    endtask

    // Drain the scoreboard with i_ready held high; returns cycles used.
    task automatic drain(input int budget, output int cyc);
        cyc = 0;
        i_ready = 1'b1;
        while (sb.size() != 0 && cyc < budget) begin
            @(posedge i_clk); #1;
            cyc++;
        end
        if (sb.size() != 0) begin
            chk("drain_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    // Scoreboard monitor: one comparison set per transferred word.
    always @(negedge i_clk) begin
        exp_t e;
        if (i_rst_n === 1'b1 && o_valid === 1'b1 && i_ready === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_beat: got data %h, want no transfer", o_data);
            end else begin
                e = sb.pop_front();
                chk("beat_data", o_data, e.data);
                chk("beat_flags", 32'({o_sof, o_last, o_side}), 32'({e.sof, e.last, e.side}));
            end
        end
    end

    task automatic run_vec(input vec_t v);
        int  cyc;
        bit  stalled;
        @(posedge i_clk); #1;
        load_quote(v.b_base, v.s_base);
        i_valid = 1'b1;
        i_ready = 1'b1;
        push_frame(v.b_base, v.s_base);
        @(negedge i_clk);
        chk("accept_ready", 32'(o_in_ready), 32'd1);
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        cyc = 0;
        while (sb.size() != 0 && cyc < 200) begin
            stalled = (cyc >= v.stall_beat) && (cyc < v.stall_beat + v.stall_len);
            i_ready = !stalled;
            if (cyc == v.drop_at) begin
                load_quote(32'hDEAD_0000, 32'hBEEF_0000);
                i_valid = 1'b1;
            end
            @(negedge i_clk);
            if (cyc == 0) begin
                chk("lat_word0", 32'({o_valid, o_sof, o_side}), 32'b110);
            end
            if (stalled) begin
                chk("stall_valid", 32'(o_valid), 32'd1);
                chk("stall_hold", o_data, beat_word(v, v.stall_beat));
            end
            if (cyc == v.drop_at) begin
                chk("drop_ready", 32'(o_in_ready), 32'd0);
                note_drop();
            end
            @(posedge i_clk); #1;
            i_valid = 1'b0;
            cyc++;
        end
        if (sb.size() != 0) sb.delete();
        i_ready = 1'b1;
        chk("frame_cycles", 32'(cyc), 32'(v.exp_cycles));
        chk("drop_cnt", 32'(o_drop_cnt), 32'(exp_drops));
    endtask

    vec_t vecs[5];

    initial begin
        int cyc;

        vecs[0] = '{32'hB000_0000, 32'h5000_0000, -1, 0, -1, 2*BEATS};
        vecs[1] = '{32'hB000_0000, 32'h5000_0000,  4, 3, -1, 2*BEATS + 3};
        vecs[2] = '{32'h1234_5670, 32'h89AB_CDE0, -1, 0,  4, 2*BEATS};
        vecs[3] = '{32'h0000_0001, 32'h0000_00A0, 12, 2, -1, 2*BEATS + 2};
        vecs[4] = '{32'hFFFF_FFF8, 32'h7FFF_FFFC, BEATS - 1, 1, -1, 2*BEATS + 1};

        i_rst_n = 1'b1;
        i_valid = 1'b0;
        i_ready = 1'b1;
        i_reg_b = '0;
        i_reg_s = '0;
        #2 i_rst_n = 1'b0;
        #1;
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_data", o_data, 32'd0);
        chk("rst_flags", 32'({o_sof, o_last, o_side}), 32'd0);
        chk("rst_drop", 32'(o_drop_cnt), 32'd0);
        chk("rst_in_ready", 32'(o_in_ready), 32'd1);
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;

        // Table: basic frame, backpressure, drop, checksum pattern, wrap.
        for (int i = 0; i < 5; i++) begin
            run_vec(vecs[i]);
        end

        // Back-to-back: new quote on the cycle the sell last word transfers.
        @(posedge i_clk); #1;
        load_quote(32'hA000_0000, 32'hC000_0000);
        i_valid = 1'b1;
        i_ready = 1'b1;
        push_frame(32'hA000_0000, 32'hC000_0000);
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        repeat (2*BEATS - 1) begin
            @(posedge i_clk); #1;
        end
        load_quote(32'hD000_0000, 32'hE000_0000);
        i_valid = 1'b1;
        @(negedge i_clk);
        chk("b2b_in_ready", 32'(o_in_ready), 32'd1);
        chk("b2b_old_last", 32'({o_last, o_side}), 32'b11);
        push_frame(32'hD000_0000, 32'hE000_0000);
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        @(negedge i_clk);
        chk("b2b_new_sof", 32'({o_valid, o_sof, o_side}), 32'b110);
        chk("b2b_new_word0", o_data, 32'hD000_0000);
        drain(100, cyc);
        chk("b2b_cycles", 32'(cyc), 32'(2*BEATS));
        chk("b2b_drop", 32'(o_drop_cnt), 32'(exp_drops));

        // Async reset mid-frame at beat 6.
        @(posedge i_clk); #1;
        load_quote(32'hB000_0000, 32'h5000_0000);
        i_valid = 1'b1;
        push_frame(32'hB000_0000, 32'h5000_0000);
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        repeat (6) begin
            @(posedge i_clk); #1;
        end
        i_rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(o_valid), 32'd0);
        chk("arst_drop", 32'(o_drop_cnt), 32'd0);
        chk("arst_data", o_data, 32'd0);
        sb.delete();
        exp_drops = '0;
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        chk("arst_in_ready", 32'(o_in_ready), 32'd1);
        run_vec('{32'h0F00_0000, 32'h0E00_0000, -1, 0, -1, 2*BEATS});

        // Drop counter saturation: frame parked with i_ready=0, strobe every cycle.
        @(posedge i_clk); #1;
        load_quote(32'h3300_0000, 32'h4400_0000);
        i_valid = 1'b1;
        i_ready = 1'b1;
        push_frame(32'h3300_0000, 32'h4400_0000);
        @(posedge i_clk); #1;
        i_ready = 1'b0;
        load_quote(32'h9999_0000, 32'h8888_0000);
        repeat (100) begin
            @(posedge i_clk);
            note_drop();
        end
        #1;
        chk("sat_mid", 32'(o_drop_cnt), 32'(exp_drops));
        repeat (65440) begin
            @(posedge i_clk);
            note_drop();
        end
        #1;
        chk("sat_full", 32'(o_drop_cnt), 32'h0000_FFFF);
        i_valid = 1'b0;
        drain(100, cyc);
        chk("sat_cycles", 32'(cyc), 32'(2*BEATS));
        chk("sat_hold", 32'(o_drop_cnt), 32'h0000_FFFF);

        repeat (3) @(posedge i_clk);
        #1;
        chk("end_idle", 32'(o_valid), 32'd0);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
